// File: rtl/imm_extend_unit.sv
// imm_extend_unit: immediate extender feeding a 2-entry ready/valid buffer.
// The extension is done when an immediate is captured, so each buffer entry
// holds the final OUT_W-bit value and its tag. out_data/out_tag come straight
// from the head entry register.
module imm_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Extend a raw immediate field according to the 2-bit mode.
  function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                 input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    case (mode)
      2'b00:   extend_imm = sext;
      2'b01:   extend_imm = {{(OUT_W-IN_W){1'b0}}, imm};
      2'b10:   extend_imm = {imm, {(OUT_W-IN_W){1'b0}}};
      2'b11:   extend_imm = {sext[OUT_W-3:0], 2'b00};
      default: extend_imm = {OUT_W{1'b0}};
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic [TAG_W-1:0] tail_tag_q, tail_tag_d;

  logic             push_s;
  logic             pop_s;
  logic [OUT_W-1:0] new_data_s;

  // Handshake flags come only from registered state, so in_ready has no path from out_ready.
  assign in_ready   = (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = head_data_q;
  assign out_tag    = head_tag_q;
  assign push_s     = in_valid && in_ready;
  assign pop_s      = out_valid && out_ready;
  assign new_data_s = extend_imm(in_imm, in_mode);

  // Next-state and entry update for the occupancy FSM.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    tail_data_d = tail_data_q;
    tail_tag_d  = tail_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          head_data_d = new_data_s;
          head_tag_d  = in_tag;
          state_d     = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          // Head leaves while the new entry takes its place.
          head_data_d = new_data_s;
          head_tag_d  = in_tag;
          state_d     = ST_ONE;
        end else if (push_s) begin
          tail_data_d = new_data_s;
          tail_tag_d  = in_tag;
          state_d     = ST_FULL;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          head_data_d = tail_data_q;
          head_tag_d  = tail_tag_q;
          state_d     = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_data_q <= {OUT_W{1'b0}};
      head_tag_q  <= {TAG_W{1'b0}};
      tail_data_q <= {OUT_W{1'b0}};
      tail_tag_q  <= {TAG_W{1'b0}};
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      tail_data_q <= tail_data_d;
      tail_tag_q  <= tail_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed self-checking bench for imm_extend_unit (default and 12/24 instances).
module tb_imm_extend_unit;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_data;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [11:0] s_in_imm;
  logic [1:0]  s_in_mode;
  logic [4:0]  s_in_tag, s_out_tag;
  logic [23:0] s_out_data;

  int n_cmp;
  int n_err;

  imm_extend_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(24), .TAG_W(5)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_imm(s_in_imm),
    .in_mode(s_in_mode), .in_tag(s_in_tag),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_tag(s_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (out_tag !== 5'd0) begin n_err++; $display("FAIL reset_out_tag got %0d want 0", out_tag); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_modes();
    logic [15:0] imms [5];
    logic [1:0]  modes[5];
    logic [31:0] exps [5];
    imms[0] = 16'h8001; modes[0] = 2'b00; exps[0] = 32'hFFFF8001;
    imms[1] = 16'h8001; modes[1] = 2'b01; exps[1] = 32'h00008001;
    imms[2] = 16'h1234; modes[2] = 2'b10; exps[2] = 32'h12340000;
    imms[3] = 16'hFFFF; modes[3] = 2'b11; exps[3] = 32'hFFFFFFFC;
    imms[4] = 16'h0004; modes[4] = 2'b11; exps[4] = 32'h00000010;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_imm = imms[i]; in_mode = modes[i]; in_tag = 5'(i + 10);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mode%0d_valid got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== exps[i]) begin n_err++; $display("FAIL mode%0d_data got %h want %h", i, out_data, exps[i]); end
      n_cmp++; if (out_tag !== 5'(i + 10)) begin n_err++; $display("FAIL mode%0d_tag got %0d want %0d", i, out_tag, i + 10); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mode%0d_drain got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'b01; in_tag = 5'd1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
    tick();
    in_imm = 16'h0002; in_tag = 5'd2;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready2 got %b want 1", in_ready); end
    tick();
    in_imm = 16'h0003; in_tag = 5'd3;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    n_cmp++; if (out_tag !== 5'd1) begin n_err++; $display("FAIL bp_head1 got %0d want 1", out_tag); end
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready got %b want 0", in_ready); end
    n_cmp++; if (out_tag !== 5'd1 || out_data !== 32'h1) begin n_err++; $display("FAIL bp_stable got %0d/%h want 1/00000001", out_tag, out_data); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_tag !== 5'd2 || out_data !== 32'h2) begin n_err++; $display("FAIL bp_pop2 got %0d/%h want 2/00000002", out_tag, out_data); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_tag !== 5'd3 || out_data !== 32'h3) begin n_err++; $display("FAIL bp_pop3 got %0d/%h want 3/00000003", out_tag, out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid3 got %b want 1", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_d;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = 16'(i * 16'h0111); in_mode = 2'b01; in_tag = 5'(i);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream%0d_ready got %b want 1", i, in_ready); end
      tick();
      exp_d = 32'(i * 16'h0111);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== 5'(i)) begin
        n_err++; $display("FAIL stream%0d got v=%b %h/%0d want v=1 %h/%0d", i, out_valid, out_data, out_tag, exp_d, i);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h00AA; in_mode = 2'b01; in_tag = 5'd4;
    tick();
    n_cmp++; if (out_data !== 32'h000000AA || out_tag !== 5'd4) begin n_err++; $display("FAIL pp_first got %h/%0d want 000000aa/4", out_data, out_tag); end
    out_ready = 1'b1; in_imm = 16'h00BB; in_tag = 5'd5;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h000000BB || out_tag !== 5'd5) begin
      n_err++; $display("FAIL pp_replace got v=%b %h/%0d want v=1 000000bb/5", out_valid, out_data, out_tag);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pp_state_one got in_ready %b want 1", in_ready); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL pp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_imm = 16'h0077; in_mode = 2'b01; in_tag = 5'd7;
    tick();
    in_imm = 16'h0088; in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rm_full got %b want 0", in_ready); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_tag !== 5'd0) begin
      n_err++; $display("FAIL rm_after got v=%b r=%b %h/%0d want v=0 r=1 00000000/0", out_valid, in_ready, out_data, out_tag);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_ghost%0d got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_param_sweep();
    s_out_ready = 1'b1;
    s_in_valid = 1'b1; s_in_imm = 12'h800; s_in_mode = 2'b00; s_in_tag = 5'd9;
    tick();
    s_in_mode = 2'b10; s_in_tag = 5'd10;
    n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 24'hFFF800) begin n_err++; $display("FAIL sweep_sext got v=%b %h want v=1 fff800", s_out_valid, s_out_data); end
    tick();
    s_in_valid = 1'b0;
    n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 24'h800000 || s_out_tag !== 5'd10) begin
      n_err++; $display("FAIL sweep_upper got v=%b %h/%0d want v=1 800000/10", s_out_valid, s_out_data, s_out_tag);
    end
    tick();
    n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL sweep_drain got %b want 0", s_out_valid); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_imm = 16'h0; in_mode = 2'b00; in_tag = 5'd0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_imm = 12'h0; s_in_mode = 2'b00; s_in_tag = 5'd0; s_out_ready = 1'b0;
    test_reset();
    test_modes();
    test_backpressure();
    test_streaming();
    test_push_pop_one();
    test_reset_mid();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
